// File: rtl/ddram_arb_pkg.sv
// Shared types and constants for the DDR3 burst-port arbiter.
package ddram_arb_pkg;

  localparam int unsigned BURST_W    = 8;
  localparam int unsigned DDR_ADDR_W = 29;
  localparam logic [15:0] TIMEOUT_MAX = 16'hFFFF;

  // Arbiter FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t RD_CMD  = 3'd1;
  localparam state_t RD_DATA = 3'd2;
  localparam state_t WR_DATA = 3'd3;
  localparam state_t DONE    = 3'd4;

  // A zero-length request still moves one beat.
  function automatic logic [BURST_W-1:0] norm_len(input logic [BURST_W-1:0] len);
    return (len == '0) ? BURST_W'(1) : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pointer and cyclic priority encoder. The channel just after
// the pointer has highest priority; the pointer moves to each new grant.
module rr_arbiter #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                _rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  output logic                valid,
  output logic [IDX_W-1:0]    grant
);

  logic [IDX_W-1:0] ptr_q;

  // Search upward from ptr+1, wrapping, for the first active request
  always_comb begin
    int unsigned j;
    valid = 1'b0;
    grant = ptr_q;
    j     = 0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!valid && req[IDX_W'(j)]) begin
        valid = 1'b1;
        grant = IDX_W'(j);
      end
    end
  end

  // Pointer starts at the last channel so channel 0 wins first after reset
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      ptr_q <= IDX_W'(CHANNELS - 1);
    end else if (en && valid) begin
      ptr_q <= grant;
    end
  end

endmodule

// File: rtl/ddram_arbiter.sv
// N-channel arbiter onto the single DDR3 burst port: round-robin grant,
// one transaction in flight, read/write bursts of 1..255 beats.
// Optional watchdog abort with per-channel ch_err: define DDRAM_ARB_TIMEOUT_EN.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 29,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                       clk,
  input  logic                       _rst,
  input  logic [CHANNELS-1:0]        ch_req,
  input  logic [CHANNELS-1:0]        ch_we,
  input  logic [CHANNELS*ADDR_W-1:0] ch_addr,
  input  logic [CHANNELS*8-1:0]      ch_len,
  input  logic [CHANNELS*DATA_W-1:0] ch_din,
  input  logic [CHANNELS*DATA_W/8-1:0] ch_be,
  output logic [CHANNELS-1:0]        ch_wready,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic [CHANNELS-1:0]        ch_rvalid,
  output logic [CHANNELS-1:0]        ch_done,
`ifdef DDRAM_ARB_TIMEOUT_EN
  output logic [CHANNELS-1:0]        ch_err,
`endif
  input  logic                       ddr_busy,
  output logic [BURST_W-1:0]         ddr_burstcnt,
  output logic [DDR_ADDR_W-1:0]      ddr_addr,
  output logic                       ddr_rd,
  output logic                       ddr_we,
  output logic [DATA_W-1:0]          ddr_din,
  output logic [DATA_W/8-1:0]        ddr_be,
  input  logic [DATA_W-1:0]          ddr_dout,
  input  logic                       ddr_dout_ready
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BE_W  = DATA_W / 8;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, arb_idx;
  logic               arb_valid, arb_en;
  logic [ADDR_W-1:0]  addr_q, sel_addr;
  logic [BURST_W-1:0] len_q, sel_len;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic               rd_cmd_acc, rd_beat, wr_beat, beat_acc, last_beat;
  logic               wdog_expire;

  assign arb_en = (state_q == IDLE);

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .clk  (clk),
    ._rst (_rst),
    .req  (ch_req),
    .en   (arb_en),
    .valid(arb_valid),
    .grant(arb_idx)
  );

  assign sel_addr = ch_addr[32'(arb_idx) * ADDR_W +: ADDR_W];
  assign sel_len  = ch_len[32'(arb_idx) * BURST_W +: BURST_W];

  // Handshake events; stray read beats outside RD_DATA never count
  assign rd_cmd_acc = (state_q == RD_CMD) && !ddr_busy;
  assign rd_beat    = (state_q == RD_DATA) && ddr_dout_ready;
  assign wr_beat    = (state_q == WR_DATA) && !ddr_busy;
  assign beat_acc   = rd_beat || wr_beat;
  assign last_beat  = (beat_q + BURST_W'(1)) == len_q;

  // Next-state and beat counter
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (arb_valid) state_d = ch_we[arb_idx] ? WR_DATA : RD_CMD;
      end
      RD_CMD: begin
        if (rd_cmd_acc) state_d = RD_DATA;
      end
      RD_DATA, WR_DATA: begin
        if (beat_acc) begin
          beat_d = beat_q + BURST_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wdog_expire) state_d = DONE;
  end

  // FSM state, beat counter and per-transaction latches
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (arb_en && arb_valid) begin
        grant_q <= arb_idx;
        addr_q  <= sel_addr;
        len_q   <= norm_len(sel_len);
      end
    end
  end

`ifdef DDRAM_ARB_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        err_q;
  logic        wdog_run, wdog_kick;

  assign wdog_run    = (state_q == RD_CMD) || (state_q == RD_DATA) || (state_q == WR_DATA);
  assign wdog_kick   = rd_cmd_acc || beat_acc;
  assign wdog_expire = wdog_run && !wdog_kick && (wdog_q == TIMEOUT_MAX);

  // Watchdog counts stalled cycles; err_q marks the DONE cycle of an abort
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!wdog_run || wdog_kick) wdog_q <= '0;
      else if (!wdog_expire)      wdog_q <= wdog_q + 16'd1;
      if (wdog_expire)            err_q <= 1'b1;
      else if (state_q == DONE)   err_q <= 1'b0;
    end
  end

  // Error pulse accompanies the done pulse of an aborted transaction
  always_comb begin
    ch_err = '0;
    ch_err[grant_q] = (state_q == DONE) && err_q;
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // DDR-side command/data and client-side strobes
  always_comb begin
    ddr_rd       = (state_q == RD_CMD);
    ddr_we       = (state_q == WR_DATA);
    ddr_addr     = DDR_ADDR_W'(addr_q);
    ddr_burstcnt = len_q;
    ddr_din      = '0;
    ddr_be       = '0;
    if (state_q == WR_DATA) begin
      ddr_din = ch_din[32'(grant_q) * DATA_W +: DATA_W];
      ddr_be  = ch_be[32'(grant_q) * BE_W +: BE_W];
    end
    ch_rdata           = (state_q == RD_DATA) ? ddr_dout : '0;
    ch_rvalid          = '0;
    ch_rvalid[grant_q] = rd_beat;
    ch_wready          = '0;
    ch_wready[grant_q] = wr_beat;
    ch_done            = '0;
    ch_done[grant_q]   = (state_q == DONE);
  end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed bench for ddram_arbiter, three channels, default widths.
module tb_ddram_arbiter;

  localparam int unsigned CH = 3;
  localparam int unsigned AW = 29;
  localparam int unsigned DW = 64;

  logic              clk = 1'b0;
  logic              _rst;
  logic [CH-1:0]     ch_req, ch_we;
  logic [CH*AW-1:0]  ch_addr;
  logic [CH*8-1:0]   ch_len;
  logic [CH*DW-1:0]  ch_din;
  logic [CH*DW/8-1:0] ch_be;
  logic [CH-1:0]     ch_wready, ch_rvalid, ch_done;
  logic [DW-1:0]     ch_rdata;
  logic              ddr_busy;
  logic [7:0]        ddr_burstcnt;
  logic [28:0]       ddr_addr;
  logic              ddr_rd, ddr_we;
  logic [DW-1:0]     ddr_din;
  logic [DW/8-1:0]   ddr_be;
  logic [DW-1:0]     ddr_dout;
  logic              ddr_dout_ready;
`ifdef DDRAM_ARB_TIMEOUT_EN
  logic [CH-1:0]     ch_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ddram_arbiter #(
    .CHANNELS(CH),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk           (clk),
    ._rst          (_rst),
    .ch_req        (ch_req),
    .ch_we         (ch_we),
    .ch_addr       (ch_addr),
    .ch_len        (ch_len),
    .ch_din        (ch_din),
    .ch_be         (ch_be),
    .ch_wready     (ch_wready),
    .ch_rdata      (ch_rdata),
    .ch_rvalid     (ch_rvalid),
    .ch_done       (ch_done),
`ifdef DDRAM_ARB_TIMEOUT_EN
    .ch_err        (ch_err),
`endif
    .ddr_busy      (ddr_busy),
    .ddr_burstcnt  (ddr_burstcnt),
    .ddr_addr      (ddr_addr),
    .ddr_rd        (ddr_rd),
    .ddr_we        (ddr_we),
    .ddr_din       (ddr_din),
    .ddr_be        (ddr_be),
    .ddr_dout      (ddr_dout),
    .ddr_dout_ready(ddr_dout_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic logic [63:0] rd_word(input int ch, input int k);
    return {32'hD0A0_0000 + 32'(ch), 32'(k)};
  endfunction

  function automatic logic [63:0] wr_word(input int k);
    return {32'hC0DE_0000 + 32'(k), 32'h1111_1111 * 32'(k + 1)};
  endfunction

  function automatic logic [63:0] onehot(input int ch);
    return 64'(1) << ch;
  endfunction

  task automatic set_req(input int ch, input logic we, input logic [28:0] addr,
                         input logic [7:0] len);
    ch_req[ch]             = 1'b1;
    ch_we[ch]              = we;
    ch_addr[ch*AW +: AW]   = addr;
    ch_len[ch*8 +: 8]      = len;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd"}, 64'(ddr_rd), 64'd0);
    check({tag, "_we"}, 64'(ddr_we), 64'd0);
    check({tag, "_addr"}, 64'(ddr_addr), 64'd0);
    check({tag, "_burstcnt"}, 64'(ddr_burstcnt), 64'd0);
    check({tag, "_outs"}, 64'({ch_done, ch_rvalid, ch_wready}), 64'd0);
    check({tag, "_din"}, ddr_din, 64'd0);
  endtask

  task automatic apply_reset();
    tick();
    _rst           = 1'b0;
    ch_req         = '0;
    ddr_dout_ready = 1'b0;
    ddr_busy       = 1'b0;
    tick();
    _rst = 1'b1;
  endtask

  // Single read burst with no back-pressure; beats expected beats follow the command
  task automatic do_read(input int ch, input logic [28:0] addr, input logic [7:0] len,
                         input int beats);
    tick();
    set_req(ch, 1'b0, addr, len);
    settle();
    check("rd_arb_latency", 64'(ddr_rd), 64'd0);
    tick();
    settle();
    check("rd_cmd", 64'(ddr_rd), 64'd1);
    check("rd_addr", 64'(ddr_addr), 64'(addr));
    check("rd_burstcnt", 64'(ddr_burstcnt), 64'(beats));
    tick();
    for (int k = 0; k < beats; k++) begin
      ddr_dout_ready = 1'b1;
      ddr_dout       = rd_word(ch, k);
      settle();
      if (k == 0) check("rd_cmd_drop", 64'(ddr_rd), 64'd0);
      check("rd_rvalid", 64'(ch_rvalid), onehot(ch));
      check("rd_rdata", ch_rdata, rd_word(ch, k));
      check("rd_no_early_done", 64'(ch_done), 64'd0);
      tick();
    end
    ddr_dout_ready = 1'b0;
    ch_req[ch]     = 1'b0;
    settle();
    check("rd_done", 64'(ch_done), onehot(ch));
    check("rd_done_no_rvalid", 64'(ch_rvalid), 64'd0);
    tick();
    settle();
    check("rd_done_clear", 64'(ch_done), 64'd0);
  endtask

  // One single-beat read while requests stay held; drop them all on the last one
  task automatic serve_read(input int exp_ch, input bit last);
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      settle();
      if (ddr_rd) seen = 1'b1;
    end
    check("rr_cmd_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("rr_addr", 64'(ddr_addr), 64'(29'h1000 + 29'(exp_ch)));
      tick();
      ddr_dout_ready = 1'b1;
      ddr_dout       = rd_word(exp_ch, 7);
      settle();
      check("rr_rvalid", 64'(ch_rvalid), onehot(exp_ch));
      tick();
      ddr_dout_ready = 1'b0;
      if (last) ch_req = '0;
      settle();
      check("rr_done", 64'(ch_done), onehot(exp_ch));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of run, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beat;
    int n_acc;
    bit busy;
    _rst           = 1'b0;
    ch_req         = '0;
    ch_we          = '0;
    ch_addr        = '0;
    ch_len         = '0;
    ch_din         = '0;
    ch_be          = '0;
    ddr_busy       = 1'b0;
    ddr_dout       = '0;
    ddr_dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    settle();
    check_quiet("reset");
    tick();
    _rst = 1'b1;

    // Stray read beat while idle
    ddr_dout_ready = 1'b1;
    ddr_dout       = 64'hDEAD_BEEF_0000_0001;
    settle();
    check("stray_idle_rvalid", 64'(ch_rvalid), 64'd0);
    tick();
    ddr_dout_ready = 1'b0;

    do_read(0, 29'h100, 8'd4, 4);

    // Write burst of 3 on ch1 with busy in WR_DATA cycles 2 and 4
    tick();
    set_req(1, 1'b1, 29'h0ABCDE, 8'd3);
    ch_be[1*8 +: 8]   = 8'hA5;
    ch_din[1*DW +: DW] = wr_word(0);
    settle();
    check("wr_arb_latency", 64'(ddr_we), 64'd0);
    beat  = 0;
    n_acc = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      busy               = (c == 2) || (c == 4);
      ddr_busy           = busy;
      ch_din[1*DW +: DW] = wr_word(beat);
      settle();
      check("wr_we", 64'(ddr_we), 64'd1);
      check("wr_din", ddr_din, wr_word(beat));
      check("wr_be", 64'(ddr_be), 64'hA5);
      check("wr_burstcnt", 64'(ddr_burstcnt), 64'd3);
      check("wr_addr", 64'(ddr_addr), 64'h0ABCDE);
      check("wr_wready", 64'(ch_wready), busy ? 64'd0 : onehot(1));
      if (ch_wready[1]) n_acc++;
      if (!busy) beat++;
    end
    tick();
    ddr_busy  = 1'b0;
    ch_req[1] = 1'b0;
    settle();
    check("wr_accept_count", 64'(n_acc), 64'd3);
    check("wr_done", 64'(ch_done), onehot(1));
    check("wr_we_drop", 64'(ddr_we), 64'd0);
    tick();
    settle();
    check("wr_done_clear", 64'(ch_done), 64'd0);

    // Length boundaries
    do_read(2, 29'h0ABC, 8'd0, 1);
    do_read(1, 29'h1FFF_FFFF, 8'd255, 255);

    // Reset after beat 2 of 8; remaining beats are stray
    tick();
    set_req(0, 1'b0, 29'h200, 8'd8);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      ddr_dout_ready = 1'b1;
      ddr_dout       = rd_word(0, k);
      settle();
      check("mid_rst_rvalid", 64'(ch_rvalid), onehot(0));
      tick();
    end
    _rst   = 1'b0;
    ch_req = '0;
    settle();
    check_quiet("mid_rst");
    tick();
    _rst = 1'b1;
    for (int k = 2; k < 8; k++) begin
      ddr_dout_ready = 1'b1;
      ddr_dout       = rd_word(0, k);
      settle();
      check("post_rst_rvalid", 64'(ch_rvalid), 64'd0);
      check("post_rst_rdata", ch_rdata, 64'd0);
      check("post_rst_rd", 64'(ddr_rd), 64'd0);
      tick();
    end
    ddr_dout_ready = 1'b0;
    do_read(0, 29'h300, 8'd2, 2);

    // Round-robin between two held requests
    apply_reset();
    set_req(0, 1'b0, 29'h1000, 8'd1);
    set_req(1, 1'b0, 29'h1001, 8'd1);
    serve_read(0, 1'b0);
    serve_read(1, 1'b0);
    serve_read(0, 1'b0);
    serve_read(1, 1'b1);

    // Round-robin among all three
    apply_reset();
    set_req(0, 1'b0, 29'h1000, 8'd1);
    set_req(1, 1'b0, 29'h1001, 8'd1);
    set_req(2, 1'b0, 29'h1002, 8'd1);
    serve_read(0, 1'b0);
    serve_read(1, 1'b0);
    serve_read(2, 1'b0);
    serve_read(0, 1'b1);
    tick();
    settle();
    check("rr_end_idle", 64'(ddr_rd), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
